router_rx_port: RTL

One input port of the 16x16 router, at the DUT end of the serial input lane. It receives the bit-serial frame_n/valid_n/din protocol for one port and asserts busy_n back to the source. It deserialises the address and payload LSB-first into bytes and buffers them in a FIFO. The FIFO feeds a byte stream with valid/ready toward the switch fabric; one instance is used per input port.

---
 rtl/router_rx_port.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/router_rx_port.sv
// One router input port: deserialises the frame_n/valid_n/din lane into bytes
// and queues them as {addr, data, last, err} entries toward the switch fabric.
module router_rx_port #(
  parameter int DEPTH      = 8,
  parameter int PAD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_n,
  input  logic       valid_n,
  input  logic       din,
  output logic       busy_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_addr,
  output logic       out_last,
  output logic       out_err,
  output logic       proto_err,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PAD, S_PAYLOAD} state_t;

  state_t          r_state;
  logic            r_frame_q;
  logic [3:0]      r_addr;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [PW-1:0]   r_pad_cnt;
  logic            r_proto_err;

  logic [13:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_busy_n;
  logic [7:0]      r_drop_cnt;

  logic [7:0]      w_bit_byte;
  logic            w_push;
  logic [13:0]     w_entry;
  logic            w_viol;
  logic            w_term_err;
  logic            w_pop;
  logic            w_full;
  logic            w_do_push;
  logic            w_drop;
  logic [AW:0]     w_count_next;
  logic [13:0]     w_head;

  // Pending byte merged with the bit being sampled this cycle.
  assign w_bit_byte = r_shift | ({7'd0, din} << r_bit_cnt);

  // Decode FIFO pushes and protocol violations for the current cycle.
  always_comb begin
    w_push     = 1'b0;
    w_entry    = 14'd0;
    w_viol     = 1'b0;
    w_term_err = 1'b0;
    case (r_state)
      S_ADDR:  w_viol = frame_n;
      S_PAD:   w_viol = frame_n | ~valid_n;
      S_PAYLOAD: begin
        if (frame_n) begin
          // Terminating entry: short byte or missing final bit marks it bad.
          w_term_err = valid_n | (r_bit_cnt != 3'd7);
          w_viol     = w_term_err;
          w_push     = 1'b1;
          w_entry    = {r_addr, (valid_n ? r_shift : w_bit_byte), 1'b1, w_term_err};
        end else if (!valid_n && (r_bit_cnt == 3'd7)) begin
          w_push  = 1'b1;
          w_entry = {r_addr, w_bit_byte, 1'b0, 1'b0};
        end else begin
          w_push = 1'b0;
        end
      end
      default: w_viol = 1'b0;
    endcase
  end

  // Receive FSM; a packet only starts on a frame_n high-to-low transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_frame_q   <= 1'b0;
      r_addr      <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_pad_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_frame_q   <= frame_n;
      r_proto_err <= w_viol;
      case (r_state)
        S_IDLE: begin
          if (!frame_n && r_frame_q) begin
            r_addr    <= {3'd0, din};
            r_bit_cnt <= 3'd1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (frame_n) begin
            r_state <= S_IDLE;
          end else begin
            r_addr[r_bit_cnt[1:0]] <= din;
            if (r_bit_cnt == 3'd3) begin
              r_pad_cnt <= '0;
              r_state   <= S_PAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        S_PAD: begin
          if (frame_n) begin
            r_state <= S_IDLE;
          end else if (r_pad_cnt == PW'(PAD_CYCLES - 1)) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_state   <= S_PAYLOAD;
          end else begin
            r_pad_cnt <= r_pad_cnt + 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (frame_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_state   <= S_IDLE;
          end else if (!valid_n) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= (r_bit_cnt == 3'd7) ? 8'd0 : w_bit_byte;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop        = (r_count != '0) && out_ready;
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_do_push    = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_count_next = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_pop);

  // FIFO storage; flushing is done through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers, occupancy, busy_n threshold and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy_n   <= 1'b1;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_next;
      // Two free slots cover the source's sampling delay plus one in-flight byte.
      r_busy_n <= (w_count_next < (AW+1)'(DEPTH - 2));
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign w_head    = (r_count != '0) ? r_mem[r_rd_ptr] : 14'd0;
  assign out_valid = (r_count != '0);
  assign out_addr  = w_head[13:10];
  assign out_data  = w_head[9:2];
  assign out_last  = w_head[1];
  assign out_err   = w_head[0];
  assign busy_n    = r_busy_n;
  assign proto_err = r_proto_err;
  assign drop_cnt  = r_drop_cnt;

endmodule
